// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: issues header^nonce message bytes to the Pearson hash
// stage and stops on the first hash below target, on nonce exhaustion, or on a hash timeout.
module nonce_search_ctrl #(
    parameter int NONCE_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         header,
    input  logic [7:0]         target,
    input  logic [NONCE_W-1:0] nonce_base,
    output logic [7:0]         hash_msg,
    output logic               hash_req,
    input  logic [7:0]         hash_in,
    input  logic               hash_done,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] nonce_out,
    output logic [7:0]         hash_out,
    output logic [NONCE_W:0]   attempts
);
    // state     | meaning
    // S_IDLE    | after reset, waiting for start
    // S_ISSUE   | hash_req pulse, message byte presented
    // S_WAIT    | waiting for hash_done, wait_cnt counts idle cycles
    // S_CHECK   | compare captured hash against target, advance nonce
    // S_FOUND   | hit, results held
    // S_EXHAUST | whole nonce space tried without a hit
    // S_ERROR   | hash stage failed to answer within TIMEOUT cycles
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUST, S_ERROR
    } state_t;

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [NONCE_W-1:0] NONCE_ONE = 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t             state;
    logic [7:0]         header_q;
    logic [7:0]         target_q;
    logic [NONCE_W-1:0] base_q;
    logic [NONCE_W-1:0] nonce;
    logic [WCW-1:0]     wait_cnt;
    logic [NONCE_W-1:0] nonce_next;
    logic [NONCE_W-1:0] nonce_last;

    assign nonce_next = nonce + NONCE_ONE;
    assign nonce_last = base_q - NONCE_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            header_q    <= '0;
            target_q    <= '0;
            base_q      <= '0;
            nonce       <= '0;
            wait_cnt    <= '0;
            hash_msg    <= '0;
            hash_req    <= 1'b0;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= '0;
            attempts    <= '0;
        end else begin
            hash_req <= 1'b0;
            case (state)
                S_IDLE, S_FOUND, S_EXHAUST, S_ERROR: begin
                    if (start) begin
                        header_q    <= header;
                        target_q    <= target;
                        base_q      <= nonce_base;
                        nonce       <= nonce_base;
                        hash_msg    <= header ^ nonce_base[7:0];
                        attempts    <= '0;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        hash_req    <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // a result arriving on the last allowed cycle still wins over the timeout
                    if (hash_done) begin
                        hash_out  <= hash_in;
                        nonce_out <= nonce;
                        state     <= S_CHECK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_CHECK: begin
                    attempts <= attempts + (NONCE_W+1)'(1);
                    if (hash_out < target_q) begin
                        found <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FOUND;
                    end else if (nonce == nonce_last) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_EXHAUST;
                    end else begin
                        nonce    <= nonce_next;
                        hash_msg <= header_q ^ nonce_next[7:0];
                        hash_req <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: a behavioural hash stage with random latency feeds the DUT,
// and a search model (plain loop over the nonce space) predicts the outcome of each run.
module tb_nonce_search_ctrl;
    localparam int NONCE_W = 8;
    localparam int TIMEOUT = 15;
    localparam int MAX_EDGES = 20000;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [7:0]         header;
    logic [7:0]         target;
    logic [NONCE_W-1:0] nonce_base;
    logic [7:0]         hash_msg;
    logic               hash_req;
    logic [7:0]         hash_in;
    logic               hash_done;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic               timeout_err;
    logic [NONCE_W-1:0] nonce_out;
    logic [7:0]         hash_out;
    logic [NONCE_W:0]   attempts;

    nonce_search_ctrl #(.NONCE_W(NONCE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .header(header), .target(target),
        .nonce_base(nonce_base), .hash_msg(hash_msg), .hash_req(hash_req),
        .hash_in(hash_in), .hash_done(hash_done), .busy(busy), .found(found),
        .exhausted(exhausted), .timeout_err(timeout_err), .nonce_out(nonce_out),
        .hash_out(hash_out), .attempts(attempts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // hash stage model
    logic [7:0] hash_tab [256];
    bit         identity = 1'b1;
    bit         stage_en = 1'b1;
    int         lat_min = 1;
    int         lat_max = 1;
    int         lat_sum = 0;
    int         req_cnt = 0;
    bit         pend = 1'b0;
    int         cnt = 0;
    logic [7:0] msg_q = '0;
    logic [7:0] cur_hdr = '0;
    logic [7:0] cur_base = '0;

    function automatic logic [7:0] hfun(input logic [7:0] m);
        return identity ? m : hash_tab[m];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
            hash_done = 1'b0;
        end else begin
            hash_done = 1'b0;
            hash_in = 8'($urandom);
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    hash_done = 1'b1;
                    hash_in = hfun(msg_q);
                    pend = 1'b0;
                end
            end
            if (hash_req && stage_en) begin
                logic [7:0] exp_msg;
                exp_msg = cur_hdr ^ (cur_base + 8'(req_cnt));
                chk("hash_msg_at_req", hash_msg, exp_msg);
                pend = 1'b1;
                cnt = $urandom_range(lat_max, lat_min);
                lat_sum += cnt;
                req_cnt++;
                msg_q = hash_msg;
            end
        end
    end

    // reference: first nonce in search order whose hash is below target, else exhaustion
    task automatic model(input logic [7:0] hdr, input logic [7:0] tgt, input logic [7:0] base,
                         output bit e_found, output logic [7:0] e_nonce,
                         output logic [7:0] e_hash, output int e_att);
        e_found = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] n;
            n = base + 8'(i);
            if (hfun(hdr ^ n) < tgt) begin
                e_found = 1'b1;
                e_nonce = n;
                e_hash = hfun(hdr ^ n);
                e_att = i + 1;
                return;
            end
        end
        e_nonce = base - 8'd1;
        e_hash = hfun(hdr ^ e_nonce);
        e_att = 256;
    endtask

    task automatic run_search(input logic [7:0] hdr, input logic [7:0] tgt,
                              input logic [7:0] base, input bit poke, input bit exp_to,
                              input int rst_at);
        bit         e_found;
        logic [7:0] e_nonce, e_hash;
        int         e_att, edges;
        model(hdr, tgt, base, e_found, e_nonce, e_hash, e_att);
        @(negedge clk);
        start = 1'b1; header = hdr; target = tgt; nonce_base = base;
        cur_hdr = hdr; cur_base = base; lat_sum = 0; req_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0; header = 8'($urandom); target = 8'($urandom); nonce_base = 8'($urandom);
        edges = 0;
        chk("after_start_flags", {busy, hash_req, found, exhausted, timeout_err}, 5'b11000);
        chk("after_start_attempts", attempts, 0);
        if (poke) begin
            @(posedge clk); #1; edges++;
            chk("msg_first_wait", hash_msg, hdr ^ base);
            start = 1'b1; header = 8'h11; target = 8'hFF; nonce_base = 8'h77;
            @(posedge clk); #1; edges++;
            start = 1'b0;
            chk("ignored_start_busy", busy, 1'b1);
            chk("ignored_start_msg", hash_msg, hdr ^ base);
        end
        while (!(found | exhausted | timeout_err) && edges < MAX_EDGES) begin
            if (rst_at != 0 && req_cnt == rst_at) begin
                reset = 1'b1;
                #1;
                chk("async_reset_outputs",
                    {hash_msg, hash_req, busy, found, exhausted, timeout_err, nonce_out,
                     hash_out, attempts}, 0);
                @(negedge clk); #3;
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1; edges++;
        end
        chk("terminal_within_bound", edges < MAX_EDGES, 1'b1);
        chk("busy_at_end", busy, 1'b0);
        if (exp_to) begin
            chk("timeout_flags", {found, exhausted, timeout_err}, 3'b001);
            chk("timeout_attempts", attempts, 0);
            chk("timeout_latency", edges, TIMEOUT + 1);
        end else begin
            chk("result_flags", {found, exhausted, timeout_err}, {e_found, !e_found, 1'b0});
            chk("nonce_out", nonce_out, e_nonce);
            chk("hash_out", hash_out, e_hash);
            chk("attempts", attempts, e_att);
            chk("requests", req_cnt, e_att);
            chk("search_cycles", edges, lat_sum + 2 * e_att);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; header = '0; target = '0; nonce_base = '0;
        hash_in = '0; hash_done = 1'b0;
        for (int i = 0; i < 256; i++) hash_tab[i] = 8'($urandom);
        #1 reset = 1'b1;
        #1;
        chk("reset_outputs",
            {hash_msg, hash_req, busy, found, exhausted, timeout_err, nonce_out, hash_out,
             attempts}, 0);
        @(negedge clk); #3 reset = 1'b0;

        identity = 1'b1; lat_min = 1; lat_max = 1;
        run_search(8'h00, 8'h05, 8'h03, 1'b0, 1'b0, 0);
        chk("first_hit_cycles", lat_sum + 2 * 1, 3);
        run_search(8'h00, 8'h05, 8'h10, 1'b0, 1'b0, 0);
        run_search(8'h00, 8'h00, 8'h42, 1'b0, 1'b0, 0);

        stage_en = 1'b0;
        run_search(8'h3C, 8'h80, 8'h00, 1'b0, 1'b1, 0);
        stage_en = 1'b1;

        lat_min = 3; lat_max = 3;
        run_search(8'hA5, 8'h05, 8'h0F, 1'b1, 1'b0, 0);

        lat_min = TIMEOUT; lat_max = TIMEOUT;
        run_search(8'h00, 8'h05, 8'h03, 1'b0, 1'b0, 0);

        lat_min = 3; lat_max = 3;
        run_search(8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 3);
        lat_min = 1; lat_max = 1;
        run_search(8'h00, 8'h05, 8'h03, 1'b0, 1'b0, 0);

        identity = 1'b0;
        for (int r = 0; r < 10; r++) begin
            lat_min = 1;
            lat_max = (r % 3 == 0) ? TIMEOUT : 4;
            run_search(8'($urandom), 8'($urandom_range(64, 1)), 8'($urandom), 1'b0, 1'b0, 0);
        end
        lat_min = 1; lat_max = 3;
        run_search(8'($urandom), 8'h00, 8'($urandom), 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nonce_search_ctrl.md
# nonce_search_ctrl

Nonce search controller sitting on both sides of the Pearson hash stage. It generates candidate message bytes from a latched header byte and an incrementing nonce, and presents each one to the hash stage. It consumes the returned 8-bit hash and compares it against a difficulty target. It stops on the first hit, on nonce-space exhaustion, or on a hash-stage timeout.

## Interface
- NONCE_W, 8: nonce width in bits; supported range 8..16.
- TIMEOUT, 15: maximum WAIT cycles allowed for hash_done; must be ≥1.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock domain, no other reset
- start  in  1  launch a search; honoured only in IDLE, FOUND, EXHAUSTED or ERROR
- header  in  8  header byte, latched on accepted start
- target  in  8  difficulty threshold, latched on accepted start; a hit requires hash < target (unsigned)
- nonce_base  in  NONCE_W  first nonce, latched on accepted start
- hash_msg  out  8  message byte to the hash stage: header_q ^ nonce[7:0]
- hash_req  out  1  one-cycle pulse; hash_msg is valid from this cycle until the hash is captured
- hash_in  in  8  hash result from the hash stage
- hash_done  in  1  hash_in is valid this cycle
- busy  out  1  high in ISSUE, WAIT and CHECK
- found  out  1  high in FOUND
- exhausted  out  1  high in EXHAUSTED
- timeout_err  out  1  high in ERROR
- nonce_out  out  NONCE_W  nonce of the last completed attempt
- hash_out  out  8  hash of the last completed attempt
- attempts  out  NONCE_W+1  completed attempts since the accepted start

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED, ERROR.
- Accepted start:
  - latch header_q, target_q and nonce = nonce_base.
  - clear attempts, found, exhausted and timeout_err.
  - go to ISSUE.
- start in ISSUE, WAIT or CHECK is ignored.
- ISSUE: hash_req = 1 for exactly one cycle, then go to WAIT. Clear wait_cnt.
- WAIT:
  - hash_done = 1: capture hash_in into hash_out and nonce into nonce_out, then go to CHECK.
  - Otherwise wait_cnt increments.
  - If wait_cnt == TIMEOUT-1 and hash_done = 0, go to ERROR.
  - hash_done is sampled only in WAIT; it is ignored in every other state.
- CHECK:
  - attempts increments.
  - If hash_out < target_q, go to FOUND.
  - Else if nonce == nonce_base_q - 1 (mod 2^NONCE_W), go to EXHAUSTED.
  - Else nonce increments with wrap-around and the FSM goes to ISSUE.
- FOUND, EXHAUSTED and ERROR hold their flag and the results until reset or an accepted start.
- target = 0 never hits: the search exhausts after exactly 2^NONCE_W attempts.
- hash_msg is held at header_q ^ nonce[7:0] in every state. It is 0 after reset.
- Only nonce[7:0] reaches the message byte. Upper nonce bits only extend the search count.

## Timing
- Reset value of every output is 0: hash_msg, hash_req, busy, found, exhausted, timeout_err, nonce_out, hash_out, attempts. State returns to IDLE and all latched registers are cleared.
- Reset asserted mid-search aborts immediately and asynchronously. No pending request survives.
- start accepted at edge N puts the FSM in ISSUE at N+1, so hash_req is high in cycle N+1.
- If hash_done is high k cycles after the hash_req cycle (1 ≤ k ≤ TIMEOUT), CHECK occupies the next cycle after that.
- Per-attempt period is k+2 cycles. The minimum is 3 cycles.
- found, exhausted and timeout_err assert in the cycle after CHECK, or after the last WAIT cycle for timeout_err.
- busy deasserts in that same cycle.
- timeout_err asserts TIMEOUT+1 cycles after the hash_req cycle when hash_done never arrives.
- start and a terminal state coexisting: the restart takes effect on the next edge and all flags clear at that edge.

## Test plan
- Identity hash model (hash_in = hash_msg, hash_done 1 cycle after hash_req); header=0x00, target=0x05, nonce_base=0x03 -> found=1, nonce_out=0x03, hash_out=0x03, attempts=1, 4 cycles after start.
- Same model; header=0x00, target=0x05, nonce_base=0x10 -> nonce wraps 0xFF→0x00; found with nonce_out=0x00, attempts=241.
- Same model; target=0x00, nonce_base=0x42 -> exhausted=1, attempts=256, nonce_out=0x41, found=0.
- hash_done never asserted, TIMEOUT=15 -> timeout_err=1 exactly 16 cycles after hash_req; busy=0; attempts=0.
- header=0xA5, nonce_base=0x0F; check hash_msg=0xAA during the first WAIT. Pulse start during WAIT -> ignored, latched values unchanged.
- reset pulsed during WAIT of the third attempt -> all outputs 0 immediately. A fresh start after reset deasserts behaves as in the first scenario.
